lcd1602_sequencer: RTL

//  Upstream command/data sequencer for the LCD 1602A nibble driver. After reset it runs
//  the 4-bit power-on init sequence, then copies a 32-byte character buffer (2x16) to DDRAM.

---
 rtl/lcd1602_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lcd1602_sequencer.sv
// LCD1602 upstream sequencer: 4-bit power-on init, then 2x16 character buffer refresh to DDRAM.
// Optional LCD_DIRTY_REFRESH_EN: refresh passes run only after buffer writes.
module lcd1602_sequencer #(
   parameter int unsigned CLK_HZ    = 20_000_000,
   parameter int unsigned T_PWR_US  = 15000,
   parameter int unsigned T_LONG_US = 4100,
   parameter int unsigned T_CLR_US  = 1640,
   parameter int unsigned T_CMD_US  = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       drv_rdy,
   output logic [7:0] drv_data,
   output logic       drv_is_data,
   output logic       drv_enable,
   output logic       init_done,
   output logic       busy
);

   localparam int unsigned CYC_US = CLK_HZ / 1_000_000;
   localparam int unsigned D_PWR  = CYC_US * T_PWR_US;
   localparam int unsigned D_LONG = CYC_US * T_LONG_US;
   localparam int unsigned D_CLR  = CYC_US * T_CLR_US;
   localparam int unsigned D_CMD  = CYC_US * T_CMD_US;
   localparam int unsigned CNT_W  = $clog2(D_PWR + 1);

   typedef enum logic [3:0] {
      PWR_WAIT, CMD_ISSUE, CMD_XFER, CMD_WAIT, IDLE,
      ADDR_ISSUE, ADDR_XFER, GAP, CHR_ISSUE, CHR_XFER
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       init_idx;
   logic [4:0]       ptr;
   logic             after_addr;
   logic             seen_low;
   logic [7:0]       char_mem [32];
   logic             xfer_done_c;
   logic [7:0]       chr_c;
`ifdef LCD_DIRTY_REFRESH_EN
   logic             dirty;
`endif

   function automatic logic [7:0] init_cmd(input logic [2:0] i);
      case (i)
         3'd0:    return 8'h33;
         3'd1:    return 8'h32;
         3'd2:    return 8'h28;
         3'd3:    return 8'h0C;
         3'd4:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] init_dly(input logic [2:0] i);
      case (i)
         3'd0:    return CNT_W'(D_LONG);
         3'd4:    return CNT_W'(D_CLR);
         default: return CNT_W'(D_CMD);
      endcase
   endfunction

   // A byte completes only on a rising drv_rdy after a low was observed in XFER.
   assign xfer_done_c = seen_low & drv_rdy;
   // Same-cycle write to the char being issued is forwarded.
   assign chr_c = (wr_en && wr_addr == ptr) ? wr_data : char_mem[ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) char_mem[i] <= 8'h20;
      end else if (wr_en) begin
         char_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= PWR_WAIT;
         cnt         <= CNT_W'(D_PWR);
         init_idx    <= '0;
         ptr         <= '0;
         after_addr  <= 1'b0;
         seen_low    <= 1'b0;
         drv_data    <= '0;
         drv_is_data <= 1'b0;
         drv_enable  <= 1'b0;
         init_done   <= 1'b0;
         busy        <= 1'b0;
`ifdef LCD_DIRTY_REFRESH_EN
         dirty       <= 1'b1;
`endif
      end else begin
         busy <= 1'b1;
`ifdef LCD_DIRTY_REFRESH_EN
         if (wr_en) dirty <= 1'b1;
`endif
         case (state)
            PWR_WAIT: begin
               if (cnt == '0) state <= CMD_ISSUE;
               else           cnt   <= cnt - CNT_W'(1);
            end
            CMD_ISSUE: begin
               drv_data    <= init_cmd(init_idx);
               drv_is_data <= 1'b0;
               drv_enable  <= 1'b1;
               seen_low    <= 1'b0;
               state       <= CMD_XFER;
            end
            CMD_XFER: begin
               if (!drv_rdy) seen_low <= 1'b1;
               if (xfer_done_c) begin
                  drv_enable <= 1'b0;
                  cnt        <= init_dly(init_idx);
                  state      <= CMD_WAIT;
               end
            end
            CMD_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (init_idx == 3'd5) begin
                  init_done <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  init_idx <= init_idx + 3'd1;
                  state    <= CMD_ISSUE;
               end
            end
            IDLE: begin
`ifdef LCD_DIRTY_REFRESH_EN
               // A write landing in the clearing cycle keeps dirty set.
               if (dirty) begin
                  dirty <= wr_en;
                  state <= ADDR_ISSUE;
               end else begin
                  busy <= 1'b0;
               end
`else
               state <= ADDR_ISSUE;
`endif
            end
            ADDR_ISSUE: begin
               drv_data    <= ptr[4] ? 8'hC0 : 8'h80;
               drv_is_data <= 1'b0;
               drv_enable  <= 1'b1;
               seen_low    <= 1'b0;
               after_addr  <= 1'b1;
               state       <= ADDR_XFER;
            end
            CHR_ISSUE: begin
               drv_data    <= chr_c;
               drv_is_data <= 1'b1;
               drv_enable  <= 1'b1;
               seen_low    <= 1'b0;
               state       <= CHR_XFER;
            end
            ADDR_XFER, CHR_XFER: begin
               if (!drv_rdy) seen_low <= 1'b1;
               if (xfer_done_c) begin
                  drv_enable <= 1'b0;
                  cnt        <= CNT_W'(D_CMD);
                  state      <= GAP;
               end
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (after_addr) begin
                  after_addr <= 1'b0;
                  state      <= CHR_ISSUE;
               end else if (ptr == 5'd31) begin
                  ptr   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  ptr   <= ptr + 5'd1;
                  state <= (ptr == 5'd15) ? ADDR_ISSUE : CHR_ISSUE;
               end
            end
            default: state <= PWR_WAIT;
         endcase
      end
   end

endmodule
